mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
Iterative multiply/divide unit with HI/LO registers, adding mult, multu, div, divu, mthi, mtlo and mfhi/mflo support to the MIPS datapath. It sits beside the ALU. Operands come from the register-file read ports, and HI/LO feed the write-back mux. It is width-parametrised and multi-cycle. Busy drives the processor's PC-hold/stall logic.

Parameters:
DATA_WIDTH, 32, operand/HI/LO width in bits (W); minimum 4.
CNT_WIDTH, 6, iteration-counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
Start  input  1  request; sampled on a rising edge only when Busy=0.
Op  input  3  operation, encoded as MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6 and 7 are no-ops.
A  input  W  rs operand: multiplicand, dividend, or MTHI/MTLO source.
B  input  W  rt operand: multiplier or divisor.
Busy  output  1  high while an iterative operation is in flight.
Done  output  1  one-cycle pulse when HI/LO take a mult/div result.
DivByZero  output  1  sticky flag, set by a div/divu with B=0, cleared at the next accepted Start.
HI  output  W  HI register.
LO  output  W  LO register.

Behaviour:
- Reset: on a clk edge with reset=1, all of the following become 0: HI, LO, Busy, Done, DivByZero, the counter and the internal registers. The state becomes IDLE. A reset during MUL/DIV/FIX aborts the operation with no partial HI/LO update.
- States: IDLE, MUL, DIV, FIX. The state, the counter and every output are registered.
- IDLE, Start=1 at edge k:
  - MULT/MULTU: latch |A| and |B| (signed) or raw A and B (unsigned), plus a result-sign bit; go to MUL.
  - DIV/DIVU: latch the same way, plus a dividend-sign bit; go to DIV.
  - MTHI/MTLO: write A into HI or LO at edge k; stay in IDLE; Busy and Done stay 0.
  - Codes 6 and 7: ignored.
  - Any accepted mult/div clears DivByZero and sets Busy=1 at edge k.
- MUL: shift-add, one multiplier bit per cycle into a 2W-bit product accumulator. Edges k+1..k+W perform the W iterations. Counter runs 0..W-1; after the last iteration go to FIX.
- DIV: restoring division, one quotient bit per cycle, same edge/counter schedule as MUL.
  - B=0: set DivByZero at edge k+1. Iterations still run, giving fixed latency. The final result is forced to HI=A as latched (original, not magnitude) and LO=all-ones.
- FIX, edge k+W+1:
  - Apply sign correction: negate the product if the operand signs differ.
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
  - Write HI (product upper / remainder) and LO (product lower / quotient).
  - Busy=0, Done=1 for one cycle; return to IDLE.
- Latency: result visible after edge k+W+1. Busy is high for W+1 cycles and Done is high in the cycle after edge k+W+1. Back-to-back: a new Start is accepted in the Done cycle.
- Start while Busy=1 is ignored, with no effect on the operation or operands. A and B are only sampled at acceptance.
- Widths: magnitudes use W-bit unsigned arithmetic. The most negative value's magnitude 2^(W-1) is represented correctly as unsigned. Overflow case DIV(most-negative, -1) gives LO=most-negative and HI=0, with no flag.
- HI/LO change only at reset, on MTHI/MTLO, or in FIX.

Decomposition:
- Op codes and state encodings are shared `define constants in the team definitions header, next to the ALU operation codes.
- One sub-module is natural: mdu_datapath. It holds the shared shift register, W+1-bit adder/subtractor and sign-fix negators, and is controlled by the FSM/counter in mult_div_unit.

Test Plan:
1. MULT A=0xFFFFFFFE (-2), B=0x00000003 → HI=0xFFFFFFFF, LO=0xFFFFFFFA; Busy high for 33 cycles, Done a single pulse.
2. MULTU A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Also MULT A=0x80000000, B=0x80000000 → HI=0x40000000, LO=0x00000000.
3. DIV A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0x00000000. DIVU 100/7 → LO=14, HI=2.
4. DIVU A=0x64, B=0 → DivByZero=1 from edge k+1, HI=0x00000064, LO=0xFFFFFFFF after 33 cycles. The next accepted Start clears the flag.
5. Start MULT, pulse Start=1 with a DIV op at cycle 10 while Busy → ignored, original MULT result intact. Assert reset at cycle 20 of a second MULT → HI=LO=0, Busy=0, Done never pulses.
6. MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 on consecutive edges → HI/LO updated on each edge, Busy=0 and Done=0 throughout. Repeat with DATA_WIDTH=8: MULTU 0xFF*0xFF → HI=0xFE, LO=0x01, Busy for 9 cycles.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared operation codes, FSM state encodings and op-decode helpers for the
// iterative multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  function automatic logic isMulDivOp(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic isSignedOp(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic isDivOp(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_mdu_datapath.sv
// Shared shift register, adder/subtractor and sign-fix negators for the
// multiply/divide unit; sequencing comes from the FSM in mult_div_unit.
module mdu_datapath
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [2:0]            Op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  divisorZero,
  output logic [DATA_WIDTH-1:0] resHi,
  output logic [DATA_WIDTH-1:0] resLo
);

  localparam int W = DATA_WIDTH;

  logic [2*W-1:0] acc;
  logic [W-1:0]   opnd;
  logic [W-1:0]   origA;
  logic           negRes;
  logic           negRem;
  logic           divMode;
  logic           bZero;

  logic [W:0]     opX;
  logic [W:0]     opY;
  logic           cin;
  logic [W+1:0]   sum;
  logic [2*W-1:0] accNext;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic sgn);
    return (sgn && v[W-1]) ? -v : v;
  endfunction

  // Shared adder: accumulate for multiply, trial-subtract (carry = no borrow) for divide
  always_comb begin
    if (divMode) begin
      opX = acc[2*W-1:W-1];
      opY = ~{1'b0, opnd};
      cin = 1'b1;
    end else begin
      opX = {1'b0, acc[2*W-1:W]};
      opY = {1'b0, opnd};
      cin = 1'b0;
    end
    sum = {1'b0, opX} + {1'b0, opY} + {{(W+1){1'b0}}, cin};
  end

  // One iteration: shift-add multiply step or restoring-division step
  always_comb begin
    if (divMode) begin
      if (sum[W+1]) begin
        accNext = {sum[W-1:0], acc[W-2:0], 1'b1};
      end else begin
        accNext = {acc[2*W-2:W-1], acc[W-2:0], 1'b0};
      end
    end else begin
      if (acc[0]) begin
        accNext = {sum[W:0], acc[W-1:1]};
      end else begin
        accNext = {1'b0, acc[2*W-1:1]};
      end
    end
  end

  // Operand latch on acceptance, iteration while stepping
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= {(2*W){1'b0}};
      opnd    <= {W{1'b0}};
      origA   <= {W{1'b0}};
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divMode <= 1'b0;
      bZero   <= 1'b0;
    end else if (load) begin
      acc     <= {{W{1'b0}}, magnitude(A, isSignedOp(Op))};
      opnd    <= magnitude(B, isSignedOp(Op));
      origA   <= A;
      negRes  <= isSignedOp(Op) & (A[W-1] ^ B[W-1]);
      negRem  <= isSignedOp(Op) & A[W-1];
      divMode <= isDivOp(Op);
      bZero   <= (B == {W{1'b0}});
    end else if (step) begin
      acc <= accNext;
    end
  end

  assign divisorZero = bZero;

  // Sign correction; quotient truncates toward zero, remainder follows the dividend
  always_comb begin
    prod = negRes ? -acc : acc;
    quo  = negRes ? -acc[W-1:0] : acc[W-1:0];
    rem  = negRem ? -acc[2*W-1:W] : acc[2*W-1:W];
    if (divMode) begin
      if (bZero) begin
        resHi = origA;
        resLo = {W{1'b1}};
      end else begin
        resHi = rem;
        resLo = quo;
      end
    end else begin
      resHi = prod[2*W-1:W];
      resLo = prod[W-1:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: FSM, iteration counter
// and architectural HI/LO state; arithmetic lives in mdu_datapath.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [2:0]            Op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivByZero,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [1:0]            state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  load;
  logic                  step;
  logic                  divisorZero;
  logic [DATA_WIDTH-1:0] resHi;
  logic [DATA_WIDTH-1:0] resLo;

  assign load = (state == ST_IDLE) && Start && isMulDivOp(Op);
  assign step = (state == ST_MUL) || (state == ST_DIV);

  mdu_datapath #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uDatapath (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .Op         (Op),
    .A          (A),
    .B          (B),
    .divisorZero(divisorZero),
    .resHi      (resHi),
    .resLo      (resLo)
  );

  // Control FSM, iteration counter and HI/LO/flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= {CNT_WIDTH{1'b0}};
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      HI        <= {DATA_WIDTH{1'b0}};
      LO        <= {DATA_WIDTH{1'b0}};
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            case (Op)
              OP_MULT, OP_MULTU: begin
                state     <= ST_MUL;
                cnt       <= {CNT_WIDTH{1'b0}};
                Busy      <= 1'b1;
                DivByZero <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                state     <= ST_DIV;
                cnt       <= {CNT_WIDTH{1'b0}};
                Busy      <= 1'b1;
                DivByZero <= 1'b0;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: begin
              end
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          // Divisor was latched at acceptance, so the flag is known on the first iteration
          if ((state == ST_DIV) && (cnt == {CNT_WIDTH{1'b0}}) && divisorZero) begin
            DivByZero <= 1'b1;
          end
          if (cnt == LAST_CNT) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        ST_FIX: begin
          HI    <= resHi;
          LO    <= resLo;
          Busy  <= 1'b0;
          Done  <= 1'b1;
          cnt   <= {CNT_WIDTH{1'b0}};
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
          cnt   <= {CNT_WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule
